// File: rtl/product_accumulator.sv
// Sums N_TERMS unsigned products from a valid/ready stream into a saturating
// accumulator, then holds the result on an output handshake until it is taken.
module product_accumulator #(
  parameter int PROD_W  = 8,
  parameter int ACC_W   = 10,
  parameter int N_TERMS = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] product_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  acc_out,
  output logic              overflow,
  output logic              busy
);

  localparam int CNT_W = $clog2(N_TERMS) + 1;
  localparam int SUM_W = ((PROD_W > ACC_W) ? PROD_W : ACC_W) + 1;
  localparam logic [ACC_W-1:0] ACC_MAX   = {ACC_W{1'b1}};
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(N_TERMS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t             state, state_next;
  logic [ACC_W-1:0]   acc_next;
  logic [CNT_W-1:0]   cnt, cnt_next;
  logic               overflow_next;
  logic [SUM_W-1:0]   sum;

  // Sum is formed wide enough for both operands so a large product is never truncated.
  assign sum = SUM_W'(acc_out) + SUM_W'(product_in);

  // Next-state and datapath update.
  always_comb begin
    state_next    = state;
    acc_next      = acc_out;
    cnt_next      = cnt;
    overflow_next = overflow;
    case (state)
      IDLE: begin
        if (start) begin
          state_next    = ACCUM;
          acc_next      = {ACC_W{1'b0}};
          cnt_next      = {CNT_W{1'b0}};
          overflow_next = 1'b0;
        end else begin
          state_next = IDLE;
        end
      end
      ACCUM: begin
        if (in_valid) begin
          if (sum > SUM_W'(ACC_MAX)) begin
            acc_next      = ACC_MAX;
            overflow_next = 1'b1;
          end else begin
            acc_next = sum[ACC_W-1:0];
          end
          cnt_next = cnt + CNT_W'(1);
          if (cnt == LAST_BEAT) begin
            state_next = HOLD;
          end else begin
            state_next = ACCUM;
          end
        end else begin
          state_next = ACCUM;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_next = IDLE;
        end else begin
          state_next = HOLD;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State, datapath and handshake flags; flags are decoded from the next state
  // so they track the state register exactly without a combinational output path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc_out   <= {ACC_W{1'b0}};
      cnt       <= {CNT_W{1'b0}};
      overflow  <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_next;
      acc_out   <= acc_next;
      cnt       <= cnt_next;
      overflow  <= overflow_next;
      in_ready  <= (state_next == ACCUM);
      out_valid <= (state_next == HOLD);
      busy      <= (state_next != IDLE);
    end
  end

endmodule
